// File: rtl/interboard_tx_arbiter.sv
// Round-robin arbiter sharing the interboard transmit channel among N_REQ message sources.
// Define TX_TIMEOUT_EN to add a per-phase handshake watchdog with a sticky tx_error flag.
module interboard_tx_arbiter #(
  parameter int N_REQ          = 3,
  parameter int MSG_W          = 3,
  parameter int NUM_W          = 5,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   interboard_rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*MSG_W-1:0] req_msg_type,
  input  logic [N_REQ*NUM_W-1:0] req_number,
  output logic [N_REQ-1:0]       done,
  input  logic                   inter_ready,
  output logic                   transmit,
  output logic                   ctrl_en,
  output logic [MSG_W-1:0]       ctrl_msg_type,
  output logic [NUM_W-1:0]       ctrl_number,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   tx_error,
  output logic [1:0]             fsm_state
);

  // Handshakes: req[i] is held until its one-cycle done[i]. transmit+ctrl_en pulse for one cycle;
  // the unit accepts by dropping inter_ready and signals completion by raising it again.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] done_onehot;
  logic             pick_found;
  logic [2:0]       pick_idx;
  logic [MSG_W-1:0] pick_msg;
  logic [NUM_W-1:0] pick_num;
  logic             grant_ok;
  logic             wd_fire;
  logic             transmit_d;
  logic             busy_d;
  logic [N_REQ-1:0] done_d;

  // The requester being released this cycle still shows req; masking it avoids a stale re-grant.
  assign req_eff     = req & ~done;
  assign done_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant_id;
    pick_msg   = '0;
    pick_num   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!pick_found && req_eff[j] && (((int'(grant_id) + k) % N_REQ) == j)) begin
          pick_found = 1'b1;
          pick_idx   = 3'(j);
          pick_msg   = req_msg_type[j*MSG_W +: MSG_W];
          pick_num   = req_number[j*NUM_W +: NUM_W];
        end
      end
    end
  end

  assign grant_ok = (state == S_IDLE) && inter_ready && pick_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (interboard_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (grant_ok) next_state = S_SEND;
      end
      S_SEND: begin
        next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!inter_ready) next_state = S_WAIT_DONE;
        else if (wd_fire) next_state = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (inter_ready || wd_fire) next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_comb begin
    transmit_d = (next_state == S_SEND);
    busy_d     = (next_state != S_IDLE);
    done_d     = '0;
    if (((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) && (next_state == S_IDLE)) begin
      done_d = done_onehot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      transmit      <= 1'b0;
      ctrl_en       <= 1'b0;
      busy          <= 1'b0;
      done          <= '0;
      ctrl_msg_type <= '0;
      ctrl_number   <= '0;
      grant_id      <= 3'(N_REQ-1);
    end else if (interboard_rst) begin
      transmit      <= 1'b0;
      ctrl_en       <= 1'b0;
      busy          <= 1'b0;
      done          <= '0;
      ctrl_msg_type <= '0;
      ctrl_number   <= '0;
      grant_id      <= 3'(N_REQ-1);
    end else begin
      transmit <= transmit_d;
      ctrl_en  <= transmit_d;
      busy     <= busy_d;
      done     <= done_d;
      if (grant_ok) begin
        grant_id      <= pick_idx;
        ctrl_msg_type <= pick_msg;
        ctrl_number   <= pick_num;
      end
    end
  end

  assign fsm_state = state;

`ifdef TX_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        in_wait;
  logic        timeout_exit;
  logic        err_q;

  assign in_wait      = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
  assign wd_fire      = in_wait && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
  // A timeout only counts when the link did not make its own progress in the same cycle.
  assign timeout_exit = wd_fire && (((state == S_WAIT_BUSY) && inter_ready) ||
                                    ((state == S_WAIT_DONE) && !inter_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else if (interboard_rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (next_state != state) wd_cnt <= '0;
      else if (in_wait) wd_cnt <= wd_cnt + 32'd1;
      if (timeout_exit) err_q <= 1'b1;
    end
  end

  assign tx_error = err_q;
`else
  assign wd_fire  = 1'b0;
  // The limit only matters with the watchdog; this folds to a constant 0.
  assign tx_error = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_interboard_tx_arbiter.sv
// Self-checking bench for interboard_tx_arbiter: transaction-level model, per-cycle compare,
// grant scoreboard and directed scenarios with hand-computed literals.
`timescale 1ns/1ps
module tb_interboard_tx_arbiter;

  localparam int N_REQ = 3;
  localparam int MSG_W = 3;
  localparam int NUM_W = 5;
  localparam int TMO   = 20;
  localparam int SB_W  = 3 + MSG_W + NUM_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic interboard_rst = 1'b0;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*MSG_W-1:0] req_msg_type = '0;
  logic [N_REQ*NUM_W-1:0] req_number = '0;
  logic                   inter_ready = 1'b1;
  logic [N_REQ-1:0]       done;
  logic                   transmit, ctrl_en, busy, tx_error;
  logic [MSG_W-1:0]       ctrl_msg_type;
  logic [NUM_W-1:0]       ctrl_number;
  logic [2:0]             grant_id;
  logic [1:0]             fsm_state;

  interboard_tx_arbiter #(
    .N_REQ(N_REQ), .MSG_W(MSG_W), .NUM_W(NUM_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
    .req(req), .req_msg_type(req_msg_type), .req_number(req_number),
    .done(done), .inter_ready(inter_ready), .transmit(transmit), .ctrl_en(ctrl_en),
    .ctrl_msg_type(ctrl_msg_type), .ctrl_number(ctrl_number), .busy(busy),
    .grant_id(grant_id), .tx_error(tx_error), .fsm_state(fsm_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A message is either absent, being announced, waiting for the link to go busy,
  // or waiting for the link to come back; completion releases the requester.
  bit               m_inflight, m_sent, m_low, m_tx, m_err;
  int               m_grant, m_wcnt;
  logic [MSG_W-1:0] m_type;
  logic [NUM_W-1:0] m_num;
  logic [N_REQ-1:0] m_done;
  logic [SB_W-1:0]  exp_q[$];

  task automatic model_reset();
    m_inflight = 0; m_sent = 0; m_low = 0; m_tx = 0; m_err = 0;
    m_grant = N_REQ - 1; m_wcnt = 0; m_type = '0; m_num = '0; m_done = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [N_REQ-1:0] elig, nd;
    bit ntx, fin;
    int c;
    nd = '0; ntx = 0; fin = 0; c = 0;
    if (!m_inflight) begin
      elig = req & ~m_done;
      if (inter_ready && elig != '0) begin
        for (int k = 1; k <= N_REQ; k++) begin
          c = (m_grant + k) % N_REQ;
          if (elig[c]) break;
        end
        m_grant = c;
        m_type = req_msg_type[c*MSG_W +: MSG_W];
        m_num = req_number[c*NUM_W +: NUM_W];
        exp_q.push_back({3'(c), m_type, m_num});
        m_inflight = 1; m_sent = 0; m_low = 0; ntx = 1;
      end
    end else if (!m_sent) begin
      m_sent = 1; m_wcnt = 0;
    end else if (!m_low) begin
      if (!inter_ready) begin m_low = 1; m_wcnt = 0; end
`ifdef TX_TIMEOUT_EN
      else if (m_wcnt == TMO - 1) begin m_err = 1; fin = 1; end
      else m_wcnt++;
`endif
    end else begin
      if (inter_ready) fin = 1;
`ifdef TX_TIMEOUT_EN
      else if (m_wcnt == TMO - 1) begin m_err = 1; fin = 1; end
      else m_wcnt++;
`endif
    end
    if (fin) begin nd[m_grant] = 1'b1; m_inflight = 0; end
    m_done = nd;
    m_tx = ntx;
  endtask

  // 0 idle, 1 announcing, 2 waiting for busy, 3 waiting for done (stimulus sequencing only)
  function automatic int model_phase();
    if (!m_inflight) return 0;
    if (!m_sent) return 1;
    if (!m_low) return 2;
    return 3;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst || interboard_rst) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process + scoreboard ----------------
  int tx_log[$];
  int done_cnt[N_REQ];
  logic [SB_W-1:0] sb;

  initial begin
    for (int i = 0; i < N_REQ; i++) done_cnt[i] = 0;
    forever begin
      @(negedge clk);
      check("transmit", 32'(transmit), 32'(m_tx));
      check("ctrl_en", 32'(ctrl_en), 32'(m_tx));
      check("busy", 32'(busy), 32'(m_inflight));
      check("done", 32'(done), 32'(m_done));
      check("grant_id", 32'(grant_id), 32'(m_grant));
      check("ctrl_msg_type", 32'(ctrl_msg_type), 32'(m_type));
      check("ctrl_number", 32'(ctrl_number), 32'(m_num));
      check("tx_error", 32'(tx_error), 32'(m_err));
      check("done_onehot", 32'($countones(done) <= 1), 1);
      for (int i = 0; i < N_REQ; i++) if (done[i] === 1'b1) done_cnt[i]++;
      if (transmit === 1'b1) begin
        tx_log.push_back(int'(grant_id));
        if (exp_q.size() == 0) begin
          check("sb_unexpected_transmit", 1, 0);
        end else begin
          sb = exp_q.pop_front();
          check("sb_grant", 32'({grant_id, ctrl_msg_type, ctrl_number}), 32'(sb));
        end
      end
    end
  end

  // ---------------- link responder ----------------
  bit link_auto = 1;
  bit link_hold_low = 0;
  int lo_delay = 1;
  int lo_len = 2;
  int lk_cnt = 0;
  int lk_low = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (lk_low > 0) lk_low--;
      else if (lk_cnt > 0) begin
        lk_cnt--;
        if (lk_cnt == 0) lk_low = lo_len;
      end
      if (link_auto && transmit === 1'b1) begin
        if (lo_delay == 0) lk_low = lo_len;
        else lk_cnt = lo_delay;
      end
      inter_ready = !(link_hold_low || lk_low > 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_payload(input int i, input int t, input int n);
    req_msg_type[i*MSG_W +: MSG_W] = MSG_W'(t);
    req_number[i*NUM_W +: NUM_W] = NUM_W'(n);
  endtask

  task automatic wait_done(input int i, input int budget, input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (done[i] === 1'b1) ok = 1;
    end
    check(name, 32'(ok), 1);
  endtask

  task automatic wait_phase(input int ph, input int budget, input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (model_phase() == ph) ok = 1;
    end
    check(name, 32'(ok), 1);
  endtask

  task automatic wait_transmit(input int budget, input string name, output int lat);
    bit ok;
    ok = 0; lat = 0;
    for (int n = 1; n <= budget && !ok; n++) begin
      @(negedge clk);
      if (transmit === 1'b1) begin ok = 1; lat = n; end
    end
    check(name, 32'(ok), 1);
  endtask

  task automatic release_req(input int i);
    @(posedge clk);
    #1;
    req[i] = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  int mark, d0, lat, nd;
  int exp_order[4] = '{0, 1, 2, 0};

  initial begin
    repeat (2) @(negedge clk);
    check("rst_grant_id", 32'(grant_id), 2);
    check("rst_busy", 32'(busy), 0);
    check("rst_transmit", 32'(transmit), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1. single request from requester 1
    lo_delay = 2;
    mark = tx_log.size();
    set_payload(1, 3, 17);
    req[1] = 1'b1;
    wait_done(1, 40, "t1_done_seen");
    check("t1_done_vec", 32'(done), 32'b010);
    check("t1_grant_id", 32'(grant_id), 1);
    check("t1_msg_type", 32'(ctrl_msg_type), 3);
    check("t1_number", 32'(ctrl_number), 17);
    release_req(1);
    repeat (8) @(negedge clk);
    check("t1_one_transmit", 32'(tx_log.size() - mark), 1);
    check("t1_one_done", 32'(done_cnt[1]), 1);
    lo_delay = 1;

    // 2. all three requesting from reset -> 0,1,2,0
    pulse_rst();
    mark = tx_log.size();
    set_payload(0, 1, 5);
    set_payload(1, 2, 9);
    set_payload(2, 4, 30);
    req = 3'b111;
    nd = 0;
    for (int n = 0; n < 200 && nd < 4; n++) begin
      @(negedge clk);
      if (done !== '0) nd++;
    end
    req = '0;
    check("t2_four_done", 32'(nd), 4);
    check("t2_four_transmits", 32'(tx_log.size() - mark), 4);
    if (tx_log.size() >= mark + 4) begin
      for (int k = 0; k < 4; k++) check("t2_grant_order", 32'(tx_log[mark+k]), 32'(exp_order[k]));
    end
    repeat (5) @(negedge clk);

    // 3. link not ready: grants stall
    link_hold_low = 1;
    @(negedge clk);
    mark = tx_log.size();
    set_payload(2, 6, 21);
    req[2] = 1'b1;
    nd = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (busy === 1'b1) nd++;
    end
    check("t3_no_transmit", 32'(tx_log.size() - mark), 0);
    check("t3_never_busy", 32'(nd), 0);
    link_hold_low = 0;
    wait_transmit(4, "t3_transmit_seen", lat);
    check("t3_latency_le2", 32'(lat <= 2), 1);
    wait_done(2, 40, "t3_done_seen");
    release_req(2);
    repeat (3) @(negedge clk);

    // 4a. async reset during WAIT_DONE aborts silently
    d0 = done_cnt[0];
    set_payload(0, 5, 11);
    req[0] = 1'b1;
    wait_phase(3, 40, "t4_reach_wait_done");
    rst = 1'b1;
    req[0] = 1'b0;
    #1;
    check("t4_rst_busy", 32'(busy), 0);
    check("t4_rst_grant_id", 32'(grant_id), 2);
    check("t4_rst_msg", 32'(ctrl_msg_type), 0);
    check("t4_rst_num", 32'(ctrl_number), 0);
    check("t4_rst_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("t4_no_done", 32'(done_cnt[0] - d0), 0);

    // 4b. soft reset during WAIT_BUSY
    set_payload(1, 7, 3);
    req[1] = 1'b1;
    wait_phase(2, 40, "t4_reach_wait_busy");
    interboard_rst = 1'b1;
    req[1] = 1'b0;
    @(negedge clk);
    interboard_rst = 1'b0;
    check("t4b_busy", 32'(busy), 0);
    check("t4b_grant_id", 32'(grant_id), 2);
    check("t4b_msg", 32'(ctrl_msg_type), 0);
    check("t4b_num", 32'(ctrl_number), 0);
    repeat (8) @(negedge clk);

    // 5. request withdrawn while in flight
    d0 = done_cnt[0];
    mark = tx_log.size();
    set_payload(0, 2, 31);
    req[0] = 1'b1;
    wait_phase(2, 40, "t5_reach_wait_busy");
    req[0] = 1'b0;
    wait_done(0, 40, "t5_done_seen");
    repeat (8) @(negedge clk);
    check("t5_one_done", 32'(done_cnt[0] - d0), 1);
    check("t5_one_transmit", 32'(tx_log.size() - mark), 1);

    // 6. link never goes busy after transmit
    link_auto = 0;
    d0 = done_cnt[2];
    set_payload(2, 1, 1);
    req[2] = 1'b1;
    wait_transmit(10, "t6_transmit_seen", lat);
`ifdef TX_TIMEOUT_EN
    lat = 0;
    for (int n = 1; n <= 30 && lat == 0; n++) begin
      @(negedge clk);
      if (done[2] === 1'b1) lat = n;
    end
    check("t6_timeout_latency", 32'(lat), 21);
    check("t6_tx_error", 32'(tx_error), 1);
    release_req(2);
    repeat (3) @(negedge clk);
    check("t6_error_sticky", 32'(tx_error), 1);
`else
    repeat (40) @(negedge clk);
    check("t6_still_busy", 32'(busy), 1);
    check("t6_no_error", 32'(tx_error), 0);
    check("t6_no_done", 32'(done_cnt[2] - d0), 0);
    interboard_rst = 1'b1;
    req[2] = 1'b0;
    @(negedge clk);
    interboard_rst = 1'b0;
`endif
    link_auto = 1;
    repeat (5) @(negedge clk);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
